ac_motor_gate_driver: RTL and testbench
=======================================

# ac_motor_gate_driver

Converts the one-hot space-vector selection (U_0/U_1/U_2/U_7) and active sector from the vector-control timing stage into six inverter gate signals, one high-side and one low-side switch per phase. Each phase leg has its own dead-time state machine, so the high and low switch of a leg are never on together. The block sits directly downstream of the vector-control timing stage and drives the power-stage gate outputs. It also latches a fault on illegal input combinations.

## Interface
- DEAD_TIME, 100, both-off interval per leg transition, in CLK cycles; legal range 1..65535 (1 µs at 100 MHz).
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  gate enable; low forces all gates off.
- SECTOR_IN  in  3  active sector from the timing stage; valid values 1..6.
- U_0  in  1  null vector V0 selected.
- U_1  in  1  first active vector of the sector selected.
- U_2  in  1  second active vector of the sector selected.
- U_7  in  1  null vector V7 selected.
- GATE_AH, GATE_AL  out  1 each  phase A high-side and low-side switch.
- GATE_BH, GATE_BL  out  1 each  phase B high-side and low-side switch.
- GATE_CH, GATE_CL  out  1 each  phase C high-side and low-side switch.
- FAULT  out  1  sticky illegal-input flag.

## Operation
- **Vector patterns (A,B,C; 1 = high side on):**
  - V0=000, V1=100, V2=110, V3=010, V4=011, V5=001, V6=101, V7=111.
- **Sector mapping:** in sector k, U_1 selects V_k and U_2 selects V_(k mod 6)+1. Sector 6 with U_2 selects V1.
- **Stage 1 (input register, one edge):**
  - Registers ENABLE, SECTOR_IN and the U_x inputs.
  - Decodes the target pattern and a target_valid flag.
- **Decode rules:**
  - Exactly one U_x high, with a legal sector: new target, target_valid=1.
  - No U_x high: hold the previous target and target_valid.
  - More than one U_x high: set FAULT.
  - U_1 or U_2 high while SECTOR_IN is 0 or 7: set FAULT.
  - U_0 or U_7 alone ignores SECTOR_IN.
- **FAULT:**
  - Sticky; cleared only by RST.
  - While FAULT=1, all six gates are 0 and every leg is held in OFF.
- **Per-leg FSM (states OFF, DEAD, HI, LO):**
  - OFF → DEAD when ENABLE_r=1, target_valid=1 and FAULT=0.
  - DEAD: both gates 0; a 16-bit counter counts DEAD_TIME cycles.
  - DEAD expiry: enter HI if the leg's target bit is 1 at that moment, else LO. Target changes during DEAD do not restart the counter.
  - HI or LO → DEAD when the target bit differs from the side currently driven.
  - Any state → OFF when ENABLE_r=0 or FAULT=1. OFF has priority over all other transitions.
  - HI drives GATE_xH=1 only. LO drives GATE_xL=1 only. OFF and DEAD drive both 0.
- **Output invariant:** GATE_xH & GATE_xL is never 1, in any cycle, for any input sequence.
- **Leg independence:** legs whose target bit is unchanged keep driving with no interruption.

## Timing
- **Reset values:** all GATE_* = 0, FAULT = 0, all legs OFF, target_valid = 0, target = 000.
- **Latency:** input change at edge E is registered at E+1. A leg leaving HI or LO shows both gates 0 from E+2.
- **Dead time:** the new side turns on at edge E+2+DEAD_TIME. Exactly DEAD_TIME cycles of both-off are observed.
- **Start-up:** the first valid vector after reset or enable also passes through DEAD_TIME before any gate turns on.
- **ENABLE deassert:** ENABLE low at edge E gives all gates 0 from E+2, including mid-DEAD. The dead counter is discarded.
- **Fault latency:** an illegal input at edge E gives FAULT=1 and all gates 0 from E+2.
- **Asynchronous reset:** RST assertion clears all outputs immediately, without waiting for a clock edge. After release, operation restarts from OFF.

## Test plan
- **Start-up:** DEAD_TIME=4, ENABLE=1, SECTOR_IN=1, U_0 pulsed → all legs DEAD for 4 cycles, then AL, BL, CL = 1 at E+6.
- **Active vector:** SECTOR_IN=1, U_0 then U_1 → phase A: AL=0 at E+2, AH=1 at E+6. B and C stay LO with no glitch.
- **Sector wrap:** SECTOR_IN=6, U_2 → pattern V1 (100). Sequence U_1 → U_2 in sector 3 (V3=010 → V4=011) → only leg C toggles.
- **Target flip during DEAD:** leg A target 1 → 0 → 1 within the dead interval → counter not restarted; AH=1 at expiry; AL never 1.
- **Faults:** U_1 and U_7 high together → FAULT=1 and all gates 0 at E+2. Remains latched after inputs return legal. Separately, SECTOR_IN=0 with U_1 → FAULT. RST clears FAULT.
- **Enable and reset mid-operation:** ENABLE low mid-DEAD → all gates 0 at E+2; re-enable → full DEAD_TIME again. RST asserted asynchronously mid-HI → all gates 0 before the next edge. The H&L=0 invariant is asserted every cycle under random stimulus.

Source files
------------

// File: rtl/ac_motor_gate_driver.sv
// Six-switch gate driver: decodes the space-vector selection into per-phase targets and
// runs one dead-time FSM per leg so a leg's high and low switches never conduct together.
module ac_motor_gate_driver #(
    parameter int unsigned DEAD_TIME = 100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic [2:0] SECTOR_IN,
    input  logic       U_0,
    input  logic       U_1,
    input  logic       U_2,
    input  logic       U_7,
    output logic       GATE_AH,
    output logic       GATE_AL,
    output logic       GATE_BH,
    output logic       GATE_BL,
    output logic       GATE_CH,
    output logic       GATE_CL,
    output logic       FAULT
);

    typedef enum logic [1:0] {
        LEG_OFF  = 2'd0,
        LEG_DEAD = 2'd1,
        LEG_HI   = 2'd2,
        LEG_LO   = 2'd3
    } leg_state_t;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_TIME - 32'd1);

    // Bit 2 is phase A, bit 0 is phase C; 1 means the high side conducts.
    function automatic logic [2:0] vec_pattern(input logic [2:0] idx);
        case (idx)
            3'd1:    return 3'b100;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b001;
            3'd6:    return 3'b101;
            3'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    logic       enable_r;
    logic [2:0] sector_r;
    logic [3:0] u_r;
    logic [2:0] target_r;
    logic       target_valid_r;
    logic       fault_r;
    logic [2:0] gate_h_r;
    logic [2:0] gate_l_r;

    logic       sector_ok_s;
    logic       multi_s;
    logic [2:0] next_sector_s;
    logic       decode_valid_s;
    logic [2:0] decode_pattern_s;
    logic       illegal_s;
    logic [2:0] target_s;
    logic       target_valid_s;
    logic [2:0] leg_target_s;
    logic       force_off_s;

    leg_state_t  leg_state_r [3];
    leg_state_t  leg_next_s  [3];
    logic [15:0] cnt_r       [3];
    logic [15:0] cnt_next_s  [3];

    // Input register stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            enable_r <= 1'b0;
            sector_r <= 3'd0;
            u_r      <= 4'd0;
        end else begin
            enable_r <= ENABLE;
            sector_r <= SECTOR_IN;
            u_r      <= {U_7, U_2, U_1, U_0};
        end
    end

    // Vector decode and illegal-combination detection from the registered inputs
    always_comb begin
        sector_ok_s      = (sector_r != 3'd0) && (sector_r != 3'd7);
        multi_s          = (u_r & (u_r - 4'd1)) != 4'd0;
        next_sector_s    = (sector_r == 3'd6) ? 3'd1 : (sector_r + 3'd1);
        decode_valid_s   = 1'b0;
        decode_pattern_s = 3'b000;
        case (u_r)
            4'b0001: begin
                decode_valid_s   = 1'b1;
                decode_pattern_s = 3'b000;
            end
            4'b1000: begin
                decode_valid_s   = 1'b1;
                decode_pattern_s = 3'b111;
            end
            4'b0010: begin
                if (sector_ok_s) begin
                    decode_valid_s   = 1'b1;
                    decode_pattern_s = vec_pattern(sector_r);
                end else begin
                    decode_valid_s   = 1'b0;
                end
            end
            4'b0100: begin
                if (sector_ok_s) begin
                    decode_valid_s   = 1'b1;
                    decode_pattern_s = vec_pattern(next_sector_s);
                end else begin
                    decode_valid_s   = 1'b0;
                end
            end
            default: begin
                decode_valid_s = 1'b0;
            end
        endcase
        illegal_s      = multi_s | ((u_r[1] | u_r[2]) & ~sector_ok_s);
        target_s       = decode_valid_s ? decode_pattern_s : target_r;
        target_valid_s = decode_valid_s | target_valid_r;
        leg_target_s   = {target_s[0], target_s[1], target_s[2]};
        force_off_s    = ~enable_r | fault_r | illegal_s;
    end

    // Held target and sticky fault
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            target_r       <= 3'b000;
            target_valid_r <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            if (decode_valid_s) begin
                target_r       <= decode_pattern_s;
                target_valid_r <= 1'b1;
            end else begin
                target_r       <= target_r;
                target_valid_r <= target_valid_r;
            end
            fault_r <= fault_r | illegal_s;
        end
    end

    // Per-leg next state; a forced off discards any dead-time count in progress
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            leg_next_s[i] = leg_state_r[i];
            cnt_next_s[i] = cnt_r[i];
            if (force_off_s) begin
                leg_next_s[i] = LEG_OFF;
                cnt_next_s[i] = 16'd0;
            end else begin
                case (leg_state_r[i])
                    LEG_OFF: begin
                        if (target_valid_s) begin
                            leg_next_s[i] = LEG_DEAD;
                            cnt_next_s[i] = 16'd0;
                        end else begin
                            leg_next_s[i] = LEG_OFF;
                        end
                    end
                    LEG_DEAD: begin
                        if (cnt_r[i] == DEAD_LAST) begin
                            leg_next_s[i] = leg_target_s[i] ? LEG_HI : LEG_LO;
                            cnt_next_s[i] = 16'd0;
                        end else begin
                            cnt_next_s[i] = cnt_r[i] + 16'd1;
                        end
                    end
                    LEG_HI: begin
                        if (!leg_target_s[i]) begin
                            leg_next_s[i] = LEG_DEAD;
                            cnt_next_s[i] = 16'd0;
                        end else begin
                            leg_next_s[i] = LEG_HI;
                        end
                    end
                    LEG_LO: begin
                        if (leg_target_s[i]) begin
                            leg_next_s[i] = LEG_DEAD;
                            cnt_next_s[i] = 16'd0;
                        end else begin
                            leg_next_s[i] = LEG_LO;
                        end
                    end
                    default: begin
                        leg_next_s[i] = LEG_OFF;
                        cnt_next_s[i] = 16'd0;
                    end
                endcase
            end
        end
    end

    // Leg state, dead counters and gate registers decoded from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                leg_state_r[i] <= LEG_OFF;
                cnt_r[i]       <= 16'd0;
            end
            gate_h_r <= 3'b000;
            gate_l_r <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                leg_state_r[i] <= leg_next_s[i];
                cnt_r[i]       <= cnt_next_s[i];
                gate_h_r[i]    <= (leg_next_s[i] == LEG_HI);
                gate_l_r[i]    <= (leg_next_s[i] == LEG_LO);
            end
        end
    end

    assign GATE_AH = gate_h_r[0];
    assign GATE_AL = gate_l_r[0];
    assign GATE_BH = gate_h_r[1];
    assign GATE_BL = gate_l_r[1];
    assign GATE_CH = gate_h_r[2];
    assign GATE_CL = gate_l_r[2];
    assign FAULT   = fault_r;

endmodule

// File: tb/tb_ac_motor_gate_driver.sv
// Bench for ac_motor_gate_driver: directed scenarios with fixed expectations, then random
// stimulus checked against a timestamp-based behavioural model of the gate timing rules.
module tb_ac_motor_gate_driver;

    localparam int D = 4;
    localparam logic [2:0] PAT [8] = '{3'b000, 3'b100, 3'b110, 3'b010,
                                       3'b011, 3'b001, 3'b101, 3'b111};

    logic       CLK = 1'b0;
    logic       RST;
    logic       ENABLE;
    logic [2:0] SECTOR_IN;
    logic       U_0, U_1, U_2, U_7;
    logic       GATE_AH, GATE_AL, GATE_BH, GATE_BL, GATE_CH, GATE_CL;
    logic       FAULT;

    int n_checks = 0;
    int n_fail   = 0;

    ac_motor_gate_driver #(.DEAD_TIME(D)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .SECTOR_IN(SECTOR_IN),
        .U_0(U_0), .U_1(U_1), .U_2(U_2), .U_7(U_7),
        .GATE_AH(GATE_AH), .GATE_AL(GATE_AL), .GATE_BH(GATE_BH),
        .GATE_BL(GATE_BL), .GATE_CH(GATE_CH), .GATE_CL(GATE_CL),
        .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    // Reference model: each leg remembers which side it drives and the edge at which
    // its current dead interval ends; inputs take effect one edge after being sampled.
    logic       m_pen;
    logic [2:0] m_psec;
    logic [3:0] m_pu;
    logic       m_fault, m_valid;
    logic [2:0] m_target;
    bit         m_run [3];
    int         m_side [3];
    int         m_de [3];
    int         m_cyc;
    logic [5:0] exp_g;
    logic       exp_fault;

    always @(posedge CLK or posedge RST) begin : ref_model
        logic [2:0] tgt;
        logic       vld, flt, off, b;
        int         ones, side_n, de_n;
        bit         run_n;
        logic [5:0] g;
        if (RST) begin
            m_pen <= 1'b0; m_psec <= 3'd0; m_pu <= 4'd0;
            m_fault <= 1'b0; m_valid <= 1'b0; m_target <= 3'd0;
            m_cyc <= 0; exp_g <= 6'd0; exp_fault <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_run[i] <= 1'b0; m_side[i] <= -1; m_de[i] <= 0;
            end
        end else begin
            tgt = m_target; vld = m_valid; flt = m_fault;
            ones = int'(m_pu[0]) + int'(m_pu[1]) + int'(m_pu[2]) + int'(m_pu[3]);
            if (ones > 1 || ((m_pu[1] || m_pu[2]) && (m_psec == 3'd0 || m_psec == 3'd7))) begin
                flt = 1'b1;
            end else if (ones == 1) begin
                vld = 1'b1;
                if (m_pu[0]) tgt = PAT[0];
                else if (m_pu[3]) tgt = PAT[7];
                else if (m_pu[1]) tgt = PAT[m_psec];
                else tgt = PAT[int'(m_psec) % 6 + 1];
            end
            off = !m_pen || flt;
            g = 6'd0;
            for (int i = 0; i < 3; i++) begin
                b = tgt[2-i];
                side_n = m_side[i]; de_n = m_de[i]; run_n = m_run[i];
                if (off) begin
                    run_n = 1'b0; side_n = -1;
                end else if (!run_n) begin
                    if (vld) begin
                        run_n = 1'b1; side_n = -1; de_n = m_cyc + D;
                    end
                end else if (side_n < 0) begin
                    if (m_cyc >= de_n) side_n = int'(b);
                end else if (side_n != int'(b)) begin
                    side_n = -1; de_n = m_cyc + D;
                end
                m_run[i] <= run_n; m_side[i] <= side_n; m_de[i] <= de_n;
                g[5-2*i] = (side_n == 1);
                g[4-2*i] = (side_n == 0);
            end
            exp_g <= g; exp_fault <= flt;
            m_fault <= flt; m_valid <= vld; m_target <= tgt;
            m_cyc <= m_cyc + 1;
            m_pen <= ENABLE; m_psec <= SECTOR_IN; m_pu <= {U_7, U_2, U_1, U_0};
        end
    end

    function automatic logic [5:0] gates();
        return {GATE_AH, GATE_AL, GATE_BH, GATE_BL, GATE_CH, GATE_CL};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_u(input logic [3:0] u);
        {U_7, U_2, U_1, U_0} = u;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL reset_gates got=%b exp=%b", gates(), 6'b000000); end
        n_checks++;
        if (FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", FAULT); end
        RST = 1'b0;
        tick(); tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL disabled_idle got=%b exp=%b", gates(), 6'b000000); end
    endtask

    task automatic test_startup();
        ENABLE = 1'b1; SECTOR_IN = 3'd1; set_u(4'b0001);
        tick(); set_u(4'b0000);
        tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL startup_dead got=%b exp=%b", gates(), 6'b000000); end
        tick(); tick(); tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL startup_e5 got=%b exp=%b", gates(), 6'b000000); end
        tick();
        n_checks++;
        if (gates() !== 6'b010101) begin n_fail++; $display("FAIL startup_on got=%b exp=%b", gates(), 6'b010101); end
    endtask

    task automatic test_active_vector();
        SECTOR_IN = 3'd1; set_u(4'b0010);
        tick();
        n_checks++;
        if (gates() !== 6'b010101) begin n_fail++; $display("FAIL active_e1 got=%b exp=%b", gates(), 6'b010101); end
        set_u(4'b0000);
        for (int k = 2; k <= 5; k++) begin
            tick();
            n_checks++;
            if (gates() !== 6'b000101) begin n_fail++; $display("FAIL active_dead_e%0d got=%b exp=%b", k, gates(), 6'b000101); end
        end
        tick();
        n_checks++;
        if (gates() !== 6'b100101) begin n_fail++; $display("FAIL active_on got=%b exp=%b", gates(), 6'b100101); end
    endtask

    task automatic test_sector_wrap();
        SECTOR_IN = 3'd3; set_u(4'b0010);
        tick(); set_u(4'b0000);
        repeat (5) tick();
        n_checks++;
        if (gates() !== 6'b011001) begin n_fail++; $display("FAIL wrap_v3 got=%b exp=%b", gates(), 6'b011001); end
        set_u(4'b0100);
        tick(); set_u(4'b0000);
        for (int k = 2; k <= 5; k++) begin
            tick();
            n_checks++;
            if (gates() !== 6'b011000) begin n_fail++; $display("FAIL wrap_only_c_e%0d got=%b exp=%b", k, gates(), 6'b011000); end
        end
        tick();
        n_checks++;
        if (gates() !== 6'b011010) begin n_fail++; $display("FAIL wrap_v4 got=%b exp=%b", gates(), 6'b011010); end
        SECTOR_IN = 3'd6; set_u(4'b0100);
        tick(); set_u(4'b0000);
        repeat (5) tick();
        n_checks++;
        if (gates() !== 6'b100101) begin n_fail++; $display("FAIL wrap_s6_v1 got=%b exp=%b", gates(), 6'b100101); end
    endtask

    task automatic test_dead_flip();
        set_u(4'b0001);
        tick();
        SECTOR_IN = 3'd1; set_u(4'b0010);
        tick();
        set_u(4'b0000);
        n_checks++;
        if (gates() !== 6'b000101) begin n_fail++; $display("FAIL flip_dead got=%b exp=%b", gates(), 6'b000101); end
        for (int k = 3; k <= 5; k++) begin
            tick();
            n_checks++;
            if ({GATE_AH, GATE_AL} !== 2'b00) begin n_fail++; $display("FAIL flip_a_off_e%0d got=%b exp=00", k, {GATE_AH, GATE_AL}); end
        end
        tick();
        n_checks++;
        if (gates() !== 6'b100101) begin n_fail++; $display("FAIL flip_expiry got=%b exp=%b", gates(), 6'b100101); end
    endtask

    task automatic test_enable();
        set_u(4'b0001);
        tick(); tick();
        set_u(4'b0000); ENABLE = 1'b0;
        tick();
        n_checks++;
        if (gates() !== 6'b000101) begin n_fail++; $display("FAIL disable_e1 got=%b exp=%b", gates(), 6'b000101); end
        tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL disable_e2 got=%b exp=%b", gates(), 6'b000000); end
        tick(); tick();
        ENABLE = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL reenable_e5 got=%b exp=%b", gates(), 6'b000000); end
        tick();
        n_checks++;
        if (gates() !== 6'b010101) begin n_fail++; $display("FAIL reenable_on got=%b exp=%b", gates(), 6'b010101); end
    endtask

    task automatic test_faults();
        SECTOR_IN = 3'd1; set_u(4'b1010);
        tick();
        n_checks++;
        if ({FAULT, gates()} !== 7'b0010101) begin n_fail++; $display("FAIL fault_e1 got=%b exp=%b", {FAULT, gates()}, 7'b0010101); end
        set_u(4'b0001);
        tick();
        n_checks++;
        if ({FAULT, gates()} !== 7'b1000000) begin n_fail++; $display("FAIL fault_e2 got=%b exp=%b", {FAULT, gates()}, 7'b1000000); end
        set_u(4'b0000);
        repeat (8) tick();
        n_checks++;
        if ({FAULT, gates()} !== 7'b1000000) begin n_fail++; $display("FAIL fault_sticky got=%b exp=%b", {FAULT, gates()}, 7'b1000000); end
        do_reset();
        n_checks++;
        if (FAULT !== 1'b0) begin n_fail++; $display("FAIL fault_rst_clear got=%b exp=0", FAULT); end
        SECTOR_IN = 3'd0; set_u(4'b0010);
        tick();
        n_checks++;
        if (FAULT !== 1'b0) begin n_fail++; $display("FAIL sector0_e1 got=%b exp=0", FAULT); end
        set_u(4'b0000);
        tick();
        n_checks++;
        if (FAULT !== 1'b1) begin n_fail++; $display("FAIL sector0_fault got=%b exp=1", FAULT); end
        do_reset();
        n_checks++;
        if (FAULT !== 1'b0) begin n_fail++; $display("FAIL sector0_rst_clear got=%b exp=0", FAULT); end
    endtask

    task automatic test_async_reset();
        SECTOR_IN = 3'd1; set_u(4'b0010);
        tick(); set_u(4'b0000);
        repeat (5) tick();
        n_checks++;
        if (gates() !== 6'b100101) begin n_fail++; $display("FAIL areset_hi got=%b exp=%b", gates(), 6'b100101); end
        #2; RST = 1'b1;
        #1;
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL areset_immediate got=%b exp=%b", gates(), 6'b000000); end
        #1; RST = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL areset_off got=%b exp=%b", gates(), 6'b000000); end
        set_u(4'b0001);
        tick(); set_u(4'b0000);
        repeat (4) tick();
        n_checks++;
        if (gates() !== 6'b000000) begin n_fail++; $display("FAIL restart_e5 got=%b exp=%b", gates(), 6'b000000); end
        tick();
        n_checks++;
        if (gates() !== 6'b010101) begin n_fail++; $display("FAIL restart_on got=%b exp=%b", gates(), 6'b010101); end
    endtask

    task automatic test_random();
        int r;
        logic [3:0] u;
        for (int c = 0; c < 1500; c++) begin
            if (ENABLE ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0)) ENABLE = ~ENABLE;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                u = 4'b0001 << $urandom_range(0, 3);
                SECTOR_IN = (u[1] || u[2]) ? 3'($urandom_range(1, 6)) : 3'($urandom_range(0, 7));
            end else if (r < 13) begin
                u = 4'($urandom_range(0, 15));
                SECTOR_IN = 3'($urandom_range(0, 7));
                if (u == 4'b0000 || u == 4'b0001 || u == 4'b1000) begin
                    u = 4'b0010;
                    SECTOR_IN = 3'd7;
                end
            end else begin
                u = 4'b0000;
                SECTOR_IN = 3'($urandom_range(0, 7));
            end
            set_u(u);
            tick();
            n_checks++;
            if (gates() !== exp_g) begin n_fail++; $display("FAIL random_gates cyc=%0d got=%b exp=%b", c, gates(), exp_g); end
            n_checks++;
            if (FAULT !== exp_fault) begin n_fail++; $display("FAIL random_fault cyc=%0d got=%b exp=%b", c, FAULT, exp_fault); end
            n_checks++;
            if ((GATE_AH & GATE_AL) | (GATE_BH & GATE_BL) | (GATE_CH & GATE_CL)) begin
                n_fail++; $display("FAIL shoot_through cyc=%0d got=%b exp=no H&L", c, gates());
            end
            if (c % 150 == 149) do_reset();
        end
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b0; SECTOR_IN = 3'd0; set_u(4'b0000);
        test_reset();
        test_startup();
        test_active_vector();
        test_sector_wrap();
        test_dead_flip();
        test_enable();
        test_faults();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
